// File: rtl/digit_board_pkg.sv
// digit_board_pkg: shared constants and types for the digit_board panel.
//   - Cell/stroke/pitch geometry (pixels, cell- or panel-relative)
//   - Seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   - Converter FSM state type
package digit_board_pkg;

  localparam int STROKE  = 10;
  localparam int CELL_W  = 30;
  localparam int CELL_H  = 50;
  localparam int PITCH   = 40;
  localparam int MARGIN  = 10;
  localparam int PANEL_H = 70;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = SEG_0;
      4'd1:    seg_pattern = SEG_1;
      4'd2:    seg_pattern = SEG_2;
      4'd3:    seg_pattern = SEG_3;
      4'd4:    seg_pattern = SEG_4;
      4'd5:    seg_pattern = SEG_5;
      4'd6:    seg_pattern = SEG_6;
      4'd7:    seg_pattern = SEG_7;
      4'd8:    seg_pattern = SEG_8;
      4'd9:    seg_pattern = SEG_9;
      default: seg_pattern = 7'h00;
    endcase
  endfunction

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/digit_board_seg_glyph.sv
// seg_glyph: combinational glyph lookup for one 30x50 digit cell.
//   digit_i [3:0] : BCD digit to draw
//   cx_i    [5:0] : cell-relative column (0..29 inside the cell)
//   cy_i    [5:0] : cell-relative row    (0..49 inside the cell)
//   lit_o         : pixel belongs to a lit segment of the digit
module seg_glyph
  import digit_board_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic [5:0] cx_i,
  input  logic [5:0] cy_i,
  output logic       lit_o
);

  logic [6:0] pat;
  int         ix;
  int         iy;

  always_comb begin
    pat   = seg_pattern(digit_i);
    ix    = 32'(cx_i);
    iy    = 32'(cy_i);
    lit_o = 1'b0;
    if (ix < CELL_W && iy < CELL_H) begin
      // Horizontal strokes span the full cell width; vertical strokes the
      // left or right 10 columns, upper or lower half (overlapping row 20-29).
      lit_o = (pat[0] && iy < STROKE)
           || (pat[6] && iy >= 2*STROKE && iy < 3*STROKE)
           || (pat[3] && iy >= 4*STROKE)
           || (pat[5] && ix < STROKE && iy < 3*STROKE)
           || (pat[1] && ix >= 2*STROKE && iy < 3*STROKE)
           || (pat[4] && ix < STROKE && iy >= 2*STROKE)
           || (pat[2] && ix >= 2*STROKE && iy >= 2*STROKE);
    end
  end

endmodule

// File: rtl/digit_board.sv
// digit_board: overlay panel showing a binary value as NDIG decimal digits.
//   clk, rst            : pixel clock, async active-high reset
//   x, y                : current pixel coordinates
//   frame_start         : pulse at the first pixel of each frame
//   value, value_valid  : binary value and load request
//   ready               : converter idle, a new value will be accepted
//   blink               : blink mode enable
//   rgb, stbd_valid     : registered pixel colour / inside-panel flag
//
// Converter FSM
//   state    | meaning
//   ST_IDLE  | waiting for value_valid, ready=1
//   ST_SHIFT | double-dabble iterations, timer counts down from VW
//   ST_DONE  | write result (or saturated 9s) to pending register
module digit_board
  import digit_board_pkg::*;
#(
  parameter int         NDIG     = 2,
  parameter int         VW       = 14,
  parameter int         X0       = 520,
  parameter int         Y0       = 0,
  parameter logic [2:0] FG       = 3'b110,
  parameter logic [2:0] BG       = 3'b011,
  parameter int         LZB      = 1,
  parameter int         BLINK_FR = 30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          frame_start,
  input  logic [VW-1:0] value,
  input  logic          value_valid,
  output logic          ready,
  input  logic          blink,
  output logic [2:0]    rgb,
  output logic          stbd_valid
);

  localparam int BW      = 4*NDIG;
  localparam int TW      = $clog2(VW+1);
  localparam int FW      = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
  localparam int MAXV    = pow10(NDIG) - 1;
  localparam int PANEL_W = PITCH*NDIG + 2*MARGIN;
  localparam logic [BW-1:0] ALL9 = {NDIG{4'd9}};

  conv_state_e   state_q, state_d;
  logic [TW-1:0] tc_q, tc_d;
  logic [VW-1:0] bin_q, bin_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic          sat_q, sat_d;
  logic [BW-1:0] pend_q, pend_d;
  logic [BW-1:0] disp_q, disp_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          valid_q, valid_d;
  logic [BW-1:0] adj;

  // Converter: the timer reaching zero is seen one cycle after the last
  // iteration, so SHIFT spans VW+1 cycles and ready is low for VW+2.
  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    sat_d   = sat_q;
    pend_d  = pend_q;
    ready   = 1'b0;
    adj     = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (value_valid) begin
          bin_d   = value;
          bcd_d   = '0;
          sat_d   = (32'(value) > 32'(MAXV));
          tc_d    = TW'(VW);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tc_q != '0) begin
          {bcd_d, bin_d} = {adj, bin_q} << 1;
          tc_d = tc_q - TW'(1);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        pend_d  = sat_q ? ALL9 : bcd_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Display latch and blink timing, both advanced only by frame_start.
  always_comb begin
    disp_d  = disp_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      // A result completing in this very cycle is shown immediately.
      disp_d = (state_q == ST_DONE) ? pend_d : pend_q;
      if (fcnt_q == FW'(BLINK_FR-1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  int         rx;
  int         ry;
  logic       in_panel;
  logic       in_cell;
  logic [3:0] cur_dig;
  logic       cur_blank;
  logic [5:0] cx;
  logic [5:0] cy;
  logic       lead;
  logic [NDIG-1:0] blank;
  logic       lit;

  always_comb begin
    lead  = 1'b1;
    blank = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (k < NDIG-1) begin
        lead     = lead && (disp_q[4*(NDIG-1-k) +: 4] == 4'd0);
        blank[k] = (LZB != 0) && lead;
      end
    end
  end

  always_comb begin
    rx        = int'(x) - X0;
    ry        = int'(y) - Y0;
    in_panel  = (rx >= 0) && (rx < PANEL_W) && (ry >= 0) && (ry < PANEL_H);
    in_cell   = 1'b0;
    cur_dig   = 4'd0;
    cur_blank = 1'b0;
    cx        = 6'd0;
    cy        = 6'(ry - MARGIN);
    for (int k = 0; k < NDIG; k++) begin
      if (rx >= MARGIN + PITCH*k && rx < MARGIN + PITCH*k + CELL_W) begin
        in_cell   = 1'b1;
        cx        = 6'(rx - MARGIN - PITCH*k);
        cur_dig   = disp_q[4*(NDIG-1-k) +: 4];
        cur_blank = blank[k];
      end
    end
    in_cell = in_cell && (ry >= MARGIN) && (ry < MARGIN + CELL_H);
  end

  seg_glyph u_glyph (
    .digit_i (cur_dig),
    .cx_i    (cx),
    .cy_i    (cy),
    .lit_o   (lit)
  );

  always_comb begin
    valid_d = in_panel;
    rgb_d   = 3'b000;
    if (in_panel) begin
      rgb_d = (in_cell && lit && !cur_blank && !(blink && phase_q)) ? FG : BG;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tc_q    <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      sat_q   <= 1'b0;
      pend_q  <= '0;
      disp_q  <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
      rgb_q   <= 3'b000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      sat_q   <= sat_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      rgb_q   <= rgb_d;
      valid_q <= valid_d;
    end
  end

  assign rgb        = rgb_q;
  assign stbd_valid = valid_q;

endmodule

// File: tb/tb_digit_board.sv
module tb_digit_board;

  localparam int X0 = 520;
  localparam int Y0 = 0;
  localparam logic [2:0] FG  = 3'b110;
  localparam logic [2:0] BG  = 3'b011;
  localparam logic [2:0] BLK = 3'b000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        frame_start = 1'b0;
  logic [13:0] value = '0;
  logic        value_valid = 1'b0;
  logic        ready;
  logic        blink = 1'b0;
  logic [2:0]  rgb;
  logic        stbd_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int fs_count = 0;
  int cnt;

  always #5 clk = ~clk;

  digit_board #(.BLINK_FR(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .value       (value),
    .value_valid (value_valid),
    .ready       (ready),
    .blink       (blink),
    .rgb         (rgb),
    .stbd_valid  (stbd_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag, input int px, input int py,
                     input logic [2:0] er, input logic ev);
    @(negedge clk);
    x = 10'(px);
    y = 10'(py);
    @(posedge clk);
    #1;
    check({tag, "_rgb"}, 32'(rgb), 32'(er));
    check({tag, "_vld"}, 32'(stbd_valid), 32'(ev));
  endtask

  task automatic fs();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    fs_count++;
  endtask

  task automatic load(input int v);
    @(negedge clk);
    value = 14'(v);
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_ready(output int c);
    c = 0;
    while (!ready && c < 100) begin
      c++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rgb", 32'(rgb), 32'(BLK));
    check("rst_vld", 32'(stbd_valid), 0);
    check("rst_ready", 32'(ready), 1);
    rst = 1'b0;
    fs_count = 0;

    // Display 0 after reset: only the least significant digit drawn
    fs();
    pix("zero_d1_a", X0+55, Y0+15, FG, 1'b1);
    pix("zero_d0_blank", X0+15, Y0+15, BG, 1'b1);

    // 57: ready low for VW+2 cycles
    load(57);
    wait_ready(cnt);
    check("ready_low_57", 32'(cnt), 16);
    pix("57_pre_fs", X0+15, Y0+15, BG, 1'b1);
    fs();
    pix("57_d0_f", X0+15, Y0+15, FG, 1'b1);
    pix("57_d1_no_g", X0+55, Y0+40, BG, 1'b1);
    pix("57_d0_c", X0+35, Y0+45, FG, 1'b1);
    pix("57_d1_no_d", X0+65, Y0+55, BG, 1'b1);
    pix("57_d0_d", X0+25, Y0+55, FG, 1'b1);
    pix("margin", X0+5, Y0+5, BG, 1'b1);
    pix("gap", X0+45, Y0+30, BG, 1'b1);
    pix("right_edge_in", X0+99, Y0+69, BG, 1'b1);
    pix("right_edge_out", X0+100, Y0+30, BLK, 1'b0);
    pix("bottom_out", X0+50, Y0+70, BLK, 1'b0);

    // 3: completes mid-frame, shown only after frame_start
    load(3);
    wait_ready(cnt);
    check("ready_low_3", 32'(cnt), 16);
    pix("3_hold_old", X0+15, Y0+15, FG, 1'b1);
    fs();
    pix("3_d0_blank", X0+15, Y0+15, BG, 1'b1);
    pix("3_d1_a", X0+55, Y0+15, FG, 1'b1);
    pix("3_d1_no_f", X0+55, Y0+25, BG, 1'b1);

    // 250 saturates; frame_start lands in the DONE cycle
    load(250);
    repeat (15) @(negedge clk);
    check("done_ready_low", 32'(ready), 0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    fs_count++;
    check("done_ready_back", 32'(ready), 1);
    pix("250_d0_b", X0+35, Y0+25, FG, 1'b1);
    pix("250_d0_a", X0+15, Y0+15, FG, 1'b1);
    pix("250_d0_no_e", X0+15, Y0+45, BG, 1'b1);

    // 100: smallest saturating value -> 99, not 00
    load(100);
    wait_ready(cnt);
    fs();
    pix("100_d1_no_e", X0+55, Y0+45, BG, 1'b1);
    pix("100_d0_no_e", X0+15, Y0+45, BG, 1'b1);

    // 10: inner zero digit is drawn
    load(10);
    wait_ready(cnt);
    fs();
    pix("10_d1_e", X0+55, Y0+45, FG, 1'b1);
    pix("10_d0_no_a", X0+15, Y0+15, BG, 1'b1);
    pix("10_d0_b", X0+35, Y0+15, FG, 1'b1);

    // Blink with BLINK_FR=2: phase flips every second frame_start
    load(88);
    wait_ready(cnt);
    blink = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fs();
      pix($sformatf("blink_seg%0d", i), X0+15, Y0+15,
          (((fs_count / 2) % 2) != 0) ? BG : FG, 1'b1);
      pix($sformatf("blink_margin%0d", i), X0+5, Y0+5, BG, 1'b1);
    end
    blink = 1'b0;

    // Reset five cycles into SHIFT
    load(42);
    repeat (4) @(negedge clk);
    check("shift_ready_low", 32'(ready), 0);
    rst = 1'b1;
    #1;
    check("rst_ready_now", 32'(ready), 1);
    @(negedge clk);
    rst = 1'b0;
    fs_count = 0;
    fs();
    pix("rst_d0_blank", X0+15, Y0+15, BG, 1'b1);
    pix("rst_d1_a", X0+55, Y0+15, FG, 1'b1);
    pix("rst_d1_f", X0+55, Y0+35, FG, 1'b1);
    pix("rst_d1_no_g", X0+65, Y0+35, BG, 1'b1);
    pix("rst_left_out", X0-1, Y0, BLK, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_board.md
DIGIT_BOARD -- requirements
Module: digit_board

Interface
REQ-001 Parameter NDIG, default 2: number of decimal digits shown (1..4).
REQ-002 Parameter VW, default 14: binary value width.
REQ-003 Parameter X0, default 520; Y0, default 0: panel top-left pixel.
REQ-004 Parameter FG, default 3'b110; BG, default 3'b011: segment and panel colours.
REQ-005 Parameter LZB, default 1: leading-zero blanking enable.
REQ-006 Parameter BLINK_FR, default 30: frames per blink half-period.
REQ-007 Port clk  in  1: pixel clock.
REQ-008 Port rst  in  1: reset; one clock; reset is asynchronous and active-high.
REQ-009 Ports x, y  in  10 each: current pixel coordinates.
REQ-010 Port frame_start  in  1: one-cycle pulse at the first pixel of each frame.
REQ-011 Port value  in  VW: binary value to display.
REQ-012 Port value_valid  in  1: load request for value.
REQ-013 Port ready  out  1: high when a new value is accepted.
REQ-014 Port blink  in  1: blink mode enable.
REQ-015 Port rgb  out  3: pixel colour.
REQ-016 Port stbd_valid  out  1: pixel lies inside the panel.

Function
REQ-017 Panel: 10-px margin; cells 30x50 px at 40-px pitch; panel width 40*NDIG+20, height 70; digit k (0 = most significant) at (X0+10+40k, Y0+10).
REQ-018 Seven segments, 10-px strokes, cell-relative: a rows 0-9; g rows 20-29; d rows 40-49; f cols 0-9, rows 0-29; b cols 20-29, rows 0-29; e cols 0-9, rows 20-49; c cols 20-29, rows 20-49.
REQ-019 Segment patterns follow standard decimal seven-segment encoding; 7 lights a, b, c only; 9 lights a, b, c, d, f, g.
REQ-020 Converter FSM states: IDLE, SHIFT, DONE; ready=1 only in IDLE.
REQ-021 IDLE with value_valid=1: capture value, go to SHIFT; value_valid while not ready is ignored (no queueing).
REQ-022 SHIFT: one double-dabble iteration per cycle for VW cycles, then DONE; DONE writes the pending BCD register and returns to IDLE; ready reasserts VW+2 cycles after acceptance.
REQ-023 value > 10^NDIG-1 saturates: all digits 9.
REQ-024 Displayed digits copy the pending register only on frame_start; a DONE and frame_start in the same cycle show the new value at that frame.
REQ-025 Leading-zero blanking (LZB=1): zero digits left of the first nonzero digit are drawn as background; the least significant digit is always drawn.
REQ-026 Frame counter counts frame_start pulses and wraps at BLINK_FR-1, toggling blink_phase on wrap; when blink=1 and blink_phase=1, all segments are background.
REQ-027 Outputs registered: rgb and stbd_valid reflect x, y of the previous cycle (latency 1).
REQ-028 Outside the panel: stbd_valid=0, rgb=3'b000.

Reset
REQ-029 rst: FSM to IDLE, ready=1, pending and displayed digits 0, frame counter 0, blink_phase 0, rgb=3'b000, stbd_valid=0.
REQ-030 rst during SHIFT discards the conversion; the display shows 0 after the next frame_start.

Structure
REQ-031 Shared package holds the segment-pattern constants, the stroke, cell and pitch geometry constants, and the FSM state typedef.
REQ-032 One sub-module, seg_glyph: combinational (digit, cell-relative x/y) -> lit.

Verification
REQ-033 rst, then NDIG=2, value=57, value_valid 1 cycle -> ready low for 16 cycles; after frame_start, pixel (X0+15,Y0+15) is FG (5 seg f); pixel (X0+55,Y0+40) is BG (7 has no g).
REQ-034 value=3 with LZB=1 -> pixel (X0+15,Y0+15) is BG (digit 0 blanked); pixel (X0+55,Y0+15) is FG (3 seg a).
REQ-035 value=250, NDIG=2 -> both digits show 9; pixel (X0+35,Y0+25) is FG (seg b).
REQ-036 New value completes mid-frame -> rgb unchanged until the next frame_start pulse, then updated.
REQ-037 blink=1, BLINK_FR=2 -> segments FG for 2 frames, BG for 2 frames; panel BG and stbd_valid=1 throughout.
REQ-038 rst asserted 5 cycles into SHIFT -> ready=1 immediately; after frame_start, only digit 1 shows 0 (LZB=1); stbd_valid=0 at (X0-1,Y0).
